afpm_operand_loader: RTL and testbench
======================================

# afpm_operand_loader

- Byte-serial front end of the logarithmic FP multiplier; sits directly upstream of the multiply core.
- Each cycle it accepts one byte of operand A (from `ui_in`) and one byte of operand B (from `uio_in`), least-significant byte first.
- It assembles two WIDTH-bit operands and presents them to the core with a valid/ready handshake.
- Default configuration carries two FP16 operands, each over two byte-cycles.

## Interface

Parameters:
- `WIDTH`, 16, operand width in bits; must be a multiple of 8 and ≥ 16.
- `EXP_W`, 5, exponent field width; used only by the classifier.
- `MAN_W`, 10, mantissa field width; `1 + EXP_W + MAN_W == WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; the top level drives it as `~rst_n`.
- `ena`  in  1  design selected; when low, no byte is accepted and state holds.
- `abort`  in  1  synchronous clear of a partial frame.
- `in_valid`  in  1  byte pair present on `byte_a` / `byte_b`.
- `in_ready`  out  1  loader can accept a byte pair this cycle.
- `byte_a`  in  8  next byte of operand A.
- `byte_b`  in  8  next byte of operand B.
- `op_valid`  out  1  `op_a` / `op_b` hold a complete operand pair.
- `op_ready`  in  1  multiply core consumes the pair this cycle.
- `op_a`  out  WIDTH  assembled operand A.
- `op_b`  out  WIDTH  assembled operand B.
- `op_flags`  out  8  classification of both operands: {A: nan, inf, zero, sub; B: nan, inf, zero, sub}.

## Operation

- Byte transfer: `acc = ena && in_valid && in_ready`.
- Operand assembly:
  - Each accepted byte shifts into the top of two WIDTH-bit shift registers: `op_a <= {byte_a, op_a[WIDTH-1:8]}`, same for B.
  - After NB = WIDTH/8 accepts, byte 0 ends up in bits [7:0].
- Byte counter `cnt`: ceil(log2(NB)) bits, range 0..NB-1; increments on `acc` and wraps to 0 on the NB-th byte.
- States:
  - COLLECT: `op_valid`=0. On `acc` with cnt==NB-1, go to FULL.
  - FULL: `op_valid`=1 and `op_a` / `op_b` stable.
    - On `op_valid && op_ready`: go to COLLECT, unless the same cycle accepts a byte that completes a frame (only possible when NB==1), in which case stay in FULL.
- `in_ready = (state==COLLECT) || op_ready`.
  - A byte accepted during the consuming cycle becomes byte 0 of the next frame.
  - The core samples the old value on that edge.
- `abort`:
  - Forces cnt=0 and state COLLECT. Shift registers are not cleared.
  - Drops a completed, unconsumed pair as well.
  - Same-cycle `acc` is ignored, so the aborted byte is lost.
  - Priority: `abort` > handshake.
- `ena` low:
  - cnt, state, registers and `op_valid` hold.
  - `in_ready` stays combinational but has no effect.
- Reset values: state=COLLECT, cnt=0, `op_a`=0, `op_b`=0, `op_valid`=0, `op_flags`=0.
  - Hence `in_ready`=1 while `rst`=0 after reset.
  - Reset mid-frame discards all partial bytes.

## Timing

- Latency: the last byte accepted at edge N gives `op_valid`=1 from edge N onward (visible in the cycle after the accept).
- Minimum frame period: NB cycles, with back-to-back accept while `op_ready`=1.
- `op_a`, `op_b` and `op_flags` stay stable while `op_valid`=1 and `op_ready`=0.
- `op_flags` is combinational from the `op_a` / `op_b` registers. No additional latency.

## Configuration

- `AFPM_CLASSIFY_EN`:
  - Defined: `op_flags` decodes each operand using fields exp = bits [WIDTH-2 -: EXP_W] and man = bits [MAN_W-1:0]:
    - nan = exp all-ones && man≠0
    - inf = exp all-ones && man==0
    - zero = exp==0 && man==0
    - sub = exp==0 && man≠0
  - Not defined: `op_flags` is tied to 8'h00 and no decode logic is generated.

## Structure

- Shared package `afpm_pkg`:
  - `AFPM_WIDTH`, `AFPM_EXP_W`, `AFPM_MAN_W`.
  - Flag bit-index localparams (NAN=3, INF=2, ZERO=1, SUB=0).
  - Loader state enum {COLLECT, FULL}.
- Sub-module `afpm_fp_classify` (one operand in, 4 flags out). Instantiated twice, only under `AFPM_CLASSIFY_EN`.

## Test plan

- Basic frame: after reset, drive (0x00, 0x00) then (0x3e, 0x42) with `in_valid`=1 and `op_ready`=0.
  - Required: `op_valid`=1 one cycle after the 2nd byte, `op_a`=0x3e00, `op_b`=0x4200, `in_ready`=0.
  - Values are held for 5 cycles of `op_ready`=0.
- Back-to-back: `op_ready` held at 1, three frames streamed (0x3c00/0x4000, 0x4400/0xc000, 0x0001/0x7c00).
  - Required: `op_valid` pulses every 2 cycles with the correct pairs and `in_ready` never drops.
- Abort mid-frame: byte 0 = (0xaa, 0xbb), then `abort`, then (0x00, 0x00), (0x3e, 0x42).
  - Required: pair is 0x3e00 / 0x4200 with no trace of 0xaa / 0xbb.
- Stall and `ena`:
  - `ena`=0 between bytes: cnt holds and the frame completes correctly when `ena` returns.
  - `in_valid`=1 while FULL with `op_ready`=0: no byte is taken.
- Classification (with `AFPM_CLASSIFY_EN`):
  - A=0x7e00, B=0x7c00 → `op_flags`=8'h84.
  - A=0x0000, B=0x0001 → 8'h21.
  - A=0x3e00, B=0x4200 → 8'h00.
  - Without the macro: always 8'h00.
- Reset mid-operation: `rst`=1 while FULL.
  - Next cycle: `op_valid`=0, `op_a`=`op_b`=0, `in_ready`=1.

Source files
------------

// File: rtl/afpm_pkg.sv
// Shared definitions for the logarithmic FP multiplier front end:
// default operand geometry, flag bit positions and the loader state type.
package afpm_pkg;

    localparam int AFPM_WIDTH = 16;
    localparam int AFPM_EXP_W = 5;
    localparam int AFPM_MAN_W = 10;

    // Bit positions inside one operand's 4-bit classification nibble
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_SUB  = 0;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } loader_state_t;

endpackage

// File: rtl/afpm_fp_classify.sv
// IEEE-style classification of one floating-point operand.
// Only the magnitude (exponent + mantissa) is passed in; the sign does not
// affect the class.
module afpm_fp_classify
    import afpm_pkg::*;
#(
    parameter int EXP_W = AFPM_EXP_W,
    parameter int MAN_W = AFPM_MAN_W
) (
    input  logic [EXP_W+MAN_W-1:0] magnitude,
    output logic [3:0]             flags
);

    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] man_field;
    logic             exp_ones;
    logic             exp_zero;
    logic             man_zero;

    assign exp_field = magnitude[EXP_W+MAN_W-1 -: EXP_W];
    assign man_field = magnitude[MAN_W-1:0];
    assign exp_ones  = &exp_field;
    assign exp_zero  = ~|exp_field;
    assign man_zero  = ~|man_field;

    // Decode the four special classes; normal numbers leave all flags clear
    always_comb begin
        flags            = 4'b0000;
        flags[FLAG_NAN]  = exp_ones && !man_zero;
        flags[FLAG_INF]  = exp_ones &&  man_zero;
        flags[FLAG_ZERO] = exp_zero &&  man_zero;
        flags[FLAG_SUB]  = exp_zero && !man_zero;
    end

endmodule

// File: rtl/afpm_operand_loader.sv
// Byte-serial operand loader for the logarithmic FP multiplier.
// Shifts one byte of A and one byte of B per accepted cycle (LSB first),
// and presents the assembled pair to the multiply core with valid/ready.
// Optional feature macro: AFPM_CLASSIFY_EN enables the op_flags decode;
// without it op_flags is constant zero.
module afpm_operand_loader
    import afpm_pkg::*;
#(
    parameter int WIDTH = AFPM_WIDTH,
    parameter int EXP_W = AFPM_EXP_W,
    parameter int MAN_W = AFPM_MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       byte_a,
    input  logic [7:0]       byte_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [7:0]       op_flags
);

    localparam int NB    = WIDTH / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

    // Reject geometries the shift path and the field split cannot handle
    if ((WIDTH % 8) != 0 || WIDTH < 16 || (1 + EXP_W + MAN_W) != WIDTH) begin : g_bad_cfg
        $error("afpm_operand_loader: inconsistent WIDTH/EXP_W/MAN_W");
    end

    loader_state_t    state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;

    logic acc;
    logic frame_done;
    logic consume;

    // A byte pair may enter whenever we are collecting, or when the held
    // pair is being consumed on this same edge.
    assign in_ready   = (state_reg == COLLECT) || op_ready;
    assign acc        = ena && in_valid && in_ready;
    assign frame_done = acc && (cnt_reg == CNT_LAST);
    assign consume    = (state_reg == FULL) && op_ready;

    // Frame control, byte counter and the two operand shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
            cnt_reg   <= '0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
        end else if (ena) begin
            if (abort) begin
                // Partial frame and any unconsumed pair are dropped; the
                // shift registers keep their contents, the byte is lost.
                state_reg <= COLLECT;
                cnt_reg   <= '0;
            end else begin
                if (acc) begin
                    op_a_reg <= {byte_a, op_a_reg[WIDTH-1:8]};
                    op_b_reg <= {byte_b, op_b_reg[WIDTH-1:8]};
                    cnt_reg  <= frame_done ? '0 : cnt_reg + 1'b1;
                end
                // Completing a frame wins over a same-cycle consume
                if (frame_done) begin
                    state_reg <= FULL;
                end else if (consume) begin
                    state_reg <= COLLECT;
                end
            end
        end
    end

    assign op_valid = (state_reg == FULL);
    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;

`ifdef AFPM_CLASSIFY_EN
    logic [3:0] flags_a;
    logic [3:0] flags_b;

    afpm_fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify_a (
        .magnitude (op_a_reg[WIDTH-2:0]),
        .flags     (flags_a)
    );

    afpm_fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify_b (
        .magnitude (op_b_reg[WIDTH-2:0]),
        .flags     (flags_b)
    );

    assign op_flags = {flags_a, flags_b};
`else
    assign op_flags = 8'h00;
`endif

endmodule

// File: tb/tb_afpm_operand_loader.sv
// Self-checking bench for afpm_operand_loader: a directed vector table,
// hand sequences for reset, then randomized traffic against a reference model.
module tb_afpm_operand_loader;

    localparam int W  = 16;
    localparam int NB = W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   byte_a;
    logic [7:0]   byte_b;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [7:0]   op_flags;

    int n_tests = 0;
    int n_fail  = 0;

    afpm_operand_loader dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .byte_a   (byte_a),
        .byte_b   (byte_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_flags (op_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Classification of a half-precision value from its bit fields
    function automatic logic [3:0] classify(input logic [15:0] v);
        int e;
        int m;
        e = (int'(v) >> 10) & 31;
        m = int'(v) & 1023;
        return {(e == 31 && m != 0), (e == 31 && m == 0), (e == 0 && m == 0), (e == 0 && m != 0)};
    endfunction

    function automatic logic [7:0] exp_flags(input logic [15:0] a, input logic [15:0] b);
`ifdef AFPM_CLASSIFY_EN
        return {classify(a), classify(b)};
`else
        return (classify(a) == 4'hf && classify(b) == 4'hf) ? 8'hff : 8'h00;
`endif
    endfunction

    // ---------------- reference model ----------------
    // Operand value = last NB accepted bytes; frame progress counted separately
    logic [7:0] hist_a[$];
    logic [7:0] hist_b[$];
    int         m_partial;
    bit         m_full;

    function automatic logic [15:0] hist_value(input logic [7:0] q[$]);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v = v | (16'(q[q.size()-NB+k]) << (8 * k));
        return v;
    endfunction

    task automatic model_reset();
        hist_a = {};
        hist_b = {};
        for (int k = 0; k < NB; k++) begin
            hist_a.push_back(8'h00);
            hist_b.push_back(8'h00);
        end
        m_partial = 0;
        m_full    = 0;
    endtask

    function automatic bit model_ready(input bit ordy);
        return !m_full || ordy;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit ab, input bit iv, input bit ordy,
                              input logic [7:0] ba, input logic [7:0] bb);
        bit take;
        bit consumed;
        take = e && iv && model_ready(ordy);
        if (r) begin
            model_reset();
        end else if (e) begin
            if (ab) begin
                m_partial = 0;
                m_full    = 0;
            end else begin
                consumed = m_full && ordy;
                if (take) begin
                    hist_a.push_back(ba);
                    hist_b.push_back(bb);
                    void'(hist_a.pop_front());
                    void'(hist_b.pop_front());
                    m_partial++;
                end
                if (m_partial == NB) begin
                    m_partial = 0;
                    m_full    = 1;
                end else if (consumed) begin
                    m_full = 0;
                end
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit         ena;
        bit         abort;
        bit         iv;
        bit         ordy;
        logic [7:0] a;
        logic [7:0] b;
        bit         x_ready;
        bit         x_valid;
        logic [15:0] xa;
        logic [15:0] xb;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1; ena = 1; abort = 0; in_valid = 0; op_ready = 0; byte_a = 0; byte_b = 0;

        // basic frame, then hold for 5 cycles
        tbl.push_back('{1,0,1,0,8'h00,8'h00, 1,0,16'h0000,16'h0000});
        tbl.push_back('{1,0,1,0,8'h3e,8'h42, 1,1,16'h3e00,16'h4200});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1,0,1,0,8'hff,8'hff, 0,1,16'h3e00,16'h4200});
        tbl.push_back('{1,0,0,1,8'h00,8'h00, 1,0,16'h3e00,16'h4200});
        // back-to-back with op_ready held high
        tbl.push_back('{1,0,1,1,8'h00,8'h00, 1,0,16'h003e,16'h0042});
        tbl.push_back('{1,0,1,1,8'h3c,8'h40, 1,1,16'h3c00,16'h4000});
        tbl.push_back('{1,0,1,1,8'h00,8'h00, 1,0,16'h003c,16'h0040});
        tbl.push_back('{1,0,1,1,8'h44,8'hc0, 1,1,16'h4400,16'hc000});
        tbl.push_back('{1,0,1,1,8'h01,8'h00, 1,0,16'h0144,16'h00c0});
        tbl.push_back('{1,0,1,1,8'h00,8'h7c, 1,1,16'h0001,16'h7c00});
        tbl.push_back('{1,0,0,1,8'h00,8'h00, 1,0,16'h0001,16'h7c00});
        // abort mid-frame
        tbl.push_back('{1,0,1,0,8'haa,8'hbb, 1,0,16'haa00,16'hbb7c});
        tbl.push_back('{1,1,1,0,8'h11,8'h22, 1,0,16'haa00,16'hbb7c});
        tbl.push_back('{1,0,1,0,8'h00,8'h00, 1,0,16'h00aa,16'h00bb});
        tbl.push_back('{1,0,1,0,8'h3e,8'h42, 1,1,16'h3e00,16'h4200});
        tbl.push_back('{1,0,0,1,8'h00,8'h00, 1,0,16'h3e00,16'h4200});
        // ena low between bytes
        tbl.push_back('{1,0,1,0,8'h00,8'h00, 1,0,16'h003e,16'h0042});
        tbl.push_back('{0,0,1,0,8'h55,8'h66, 1,0,16'h003e,16'h0042});
        tbl.push_back('{0,0,1,0,8'h55,8'h66, 1,0,16'h003e,16'h0042});
        tbl.push_back('{1,0,1,0,8'h7e,8'h7c, 1,1,16'h7e00,16'h7c00});
        tbl.push_back('{1,0,0,1,8'h00,8'h00, 1,0,16'h7e00,16'h7c00});
        tbl.push_back('{1,0,1,0,8'h00,8'h01, 1,0,16'h007e,16'h017c});
        tbl.push_back('{1,0,1,0,8'h00,8'h00, 1,1,16'h0000,16'h0001});
        // ena low while FULL: consume request has no effect
        tbl.push_back('{0,0,0,1,8'h00,8'h00, 1,1,16'h0000,16'h0001});

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("reset_op_valid", 32'(op_valid), 32'd0);
        chk("reset_op_a", 32'(op_a), 32'h0);
        chk("reset_op_b", 32'(op_b), 32'h0);
        chk("reset_op_flags", 32'(op_flags), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // classification constants for the spec's reference pairs
        chk("flags_const_nan_inf", 32'(exp_flags(16'h7e00, 16'h7c00)),
`ifdef AFPM_CLASSIFY_EN
            32'h84);
`else
            32'h00);
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            ena = tbl[i].ena; abort = tbl[i].abort; in_valid = tbl[i].iv;
            op_ready = tbl[i].ordy; byte_a = tbl[i].a; byte_b = tbl[i].b;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].x_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_op_valid", i), 32'(op_valid), 32'(tbl[i].x_valid));
            chk($sformatf("vec%0d_op_a", i), 32'(op_a), 32'(tbl[i].xa));
            chk($sformatf("vec%0d_op_b", i), 32'(op_b), 32'(tbl[i].xb));
            chk($sformatf("vec%0d_op_flags", i), 32'(op_flags), 32'(exp_flags(tbl[i].xa, tbl[i].xb)));
            $display("[TB] vec %0d a=%h b=%h valid=%0d flags=%h", i, op_a, op_b, op_valid, op_flags);
        end

        // reset while FULL
        @(negedge clk);
        ena = 1; abort = 0; in_valid = 1; op_ready = 0; byte_a = 8'h12; byte_b = 8'h34;
        rst = 1;
        @(posedge clk);
        #1;
        chk("rstfull_op_valid", 32'(op_valid), 32'd0);
        chk("rstfull_op_a", 32'(op_a), 32'h0);
        chk("rstfull_op_b", 32'(op_b), 32'h0);
        chk("rstfull_in_ready", 32'(in_ready), 32'd1);
        $display("[TB] reset-while-full valid=%0d a=%h b=%h", op_valid, op_a, op_b);

        // randomized traffic against the reference model
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bit r_r, r_e, r_ab, r_iv, r_or;
            logic [7:0] r_a, r_b;
            logic [15:0] xa, xb;
            @(negedge clk);
            r_r  = ($urandom_range(0, 99) < 2);
            r_e  = ($urandom_range(0, 99) < 90);
            r_ab = ($urandom_range(0, 99) < 5);
            r_iv = ($urandom_range(0, 99) < 70);
            r_or = ($urandom_range(0, 99) < 50);
            r_a  = 8'($urandom);
            r_b  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r_a = 8'h7c | (r_a & 8'h83);
            rst = r_r; ena = r_e; abort = r_ab; in_valid = r_iv; op_ready = r_or;
            byte_a = r_a; byte_b = r_b;
            #1;
            chk($sformatf("rnd%0d_in_ready", i), 32'(in_ready), 32'(model_ready(r_or)));
            model_edge(r_r, r_e, r_ab, r_iv, r_or, r_a, r_b);
            xa = hist_value(hist_a);
            xb = hist_value(hist_b);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_op_valid", i), 32'(op_valid), 32'(m_full));
            chk($sformatf("rnd%0d_op_a", i), 32'(op_a), 32'(xa));
            chk($sformatf("rnd%0d_op_b", i), 32'(op_b), 32'(xb));
            chk($sformatf("rnd%0d_op_flags", i), 32'(op_flags), 32'(exp_flags(xa, xb)));
            $display("[TB] rnd %0d rst=%0d ena=%0d abort=%0d iv=%0d ordy=%0d a=%h b=%h valid=%0d",
                     i, r_r, r_e, r_ab, r_iv, r_or, op_a, op_b, op_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
